pe_inject_queue: RTL and testbench
==================================

// Module: pe_inject_queue
// PURPOSE
//  PE-side injection queue feeding a ring switch's PE input (pe_fifo_in). Buffers PE-generated
//  tokens and presents one only in cycles where the ring input of the same switch is idle.
//  The switch gives PE injection priority over ring traffic, so gating on ring idle means no
//  ring token is ever overwritten. Also reports starvation.
//  Byte encoding on the ring: 8'h00 = idle, any non-zero byte = valid token.
// PARAMETERS
//  RANK       0  rank of the attached switch, 0..3; self-addressed tokens are discarded.
//  DEPTH      4  queue entries, power of two, 2..16.
//  STARVE_MAX 15 consecutive blocked cycles (queue non-empty, ring busy) before starve asserts.
// PORTS
//  clk         in   1  system clock, all state on rising edge.
//  rst_n       in   1  asynchronous active-low reset.
//  pe_valid    in   1  PE offers a token this cycle.
//  pe_data     in   6  [5:4] destination rank, [3:0] payload.
//  pe_ready    out  1  queue can accept; a transfer occurs when pe_valid & pe_ready.
//  ring_snoop  in   8  the byte on the switch's ring input (switch_fifo_in) this cycle.
//  inj_out     out  8  to switch pe_fifo_in; 8'h00 when not injecting.
//  level       out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
//  starve      out  1  blocked-cycle counter has reached STARVE_MAX.
//  drop_cnt    out  8  count of self-addressed tokens discarded, saturates at 8'hFF.
// BEHAVIOUR
//  Reset (async, rst_n=0): queue empty, level=0, pe_ready=1, inj_out=8'h00, starve=0,
//   drop_cnt=0, blocked counter=0. Reset mid-operation discards all queued tokens.
//  Enqueue: on a rising edge with pe_valid & pe_ready:
//   - if pe_data[5:4]==RANK: token not stored; drop_cnt increments (saturating).
//   - else: stored at tail, occupancy +1.
//  pe_ready = (level < DEPTH), combinational from registered level. A full queue that pops
//   this cycle still shows pe_ready=0; no fall-through.
//  Inject condition inj = (level!=0) && (ring_snoop==8'h00), combinational.
//  inj_out = inj ? {2'b10, head[5:4], head[3:0]} : 8'h00. Bit7 is always 1, so a token with
//   payload 0 is still non-zero. inj_out is combinational from the head register and
//   ring_snoop, with zero-cycle latency to the switch.
//  Pop: on a rising edge with inj=1, the head is removed. Each token is presented in exactly
//   one cycle.
//  Simultaneous push and pop: occupancy unchanged and both take effect. This holds at
//   level==1 (the new token becomes the head) and at any level < DEPTH.
//  Empty queue: no fall-through. A token written at edge k is injectable at the earliest in
//   the cycle after edge k.
//  FIFO order is strict. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  Blocked counter:
//   - increments (saturating at STARVE_MAX) on each edge where level!=0 and ring_snoop!=0.
//   - clears on any edge where inj=1 or level==0.
//   - starve = (counter == STARVE_MAX), registered.
//  ring_snoop is used only for the ==0 compare; its contents are otherwise ignored.
// TESTING
//  1) Reset, RANK=0, ring idle; push 6'b01_0101 -> inj_out=8'h95 the next cycle for one cycle,
//     then 8'h00; level returns 0.
//  2) Ring busy (ring_snoop=8'h23); push 4 tokens -> inj_out stays 00, level=4, pe_ready=0,
//     starve=1 after 15 blocked edges; release ring -> 4 tokens out in order over 4 cycles,
//     starve clears.
//  3) Push dest==RANK (6'b00_0011 with RANK=0) -> not queued, level unchanged, drop_cnt 0->1;
//     300 such pushes -> drop_cnt=8'hFF.
//  4) Payload 0, dest 2 (6'b10_0000) -> inj_out=8'hA0 (non-zero).
//  5) Continuous push every cycle with the ring alternating busy/idle -> no loss and no
//     reordering; simultaneous push and pop at level 1 keeps level 1; pointer wrap over
//     20 tokens is checked.
//  6) Assert rst_n=0 asynchronously with 3 tokens queued -> inj_out=00 and level=0
//     immediately, no token emitted after release.

Source files
------------

// File: rtl/pe_inject_queue_if.sv
// rtl/pe_inject_queue_if.sv - PE-to-injection-queue token handshake
//   pe_valid : PE offers a token this cycle
//   pe_data  : [5:4] destination rank, [3:0] payload
//   pe_ready : queue can accept; a transfer occurs when pe_valid & pe_ready
//   master   : the PE side, which drives the token
//   slave    : the queue side, which accepts it
interface pe_inject_queue_if;
  logic       pe_valid;
  logic [5:0] pe_data;
  logic       pe_ready;

  modport master (output pe_valid, output pe_data, input pe_ready);
  modport slave  (input pe_valid, input pe_data, output pe_ready);
endinterface

// File: rtl/pe_inject_queue.sv
// rtl/pe_inject_queue.sv - PE injection queue that injects only into idle ring slots
//   clk          : system clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   pe           : token handshake from the PE (slave side)
//   ring_snoop_i : byte on the switch ring input this cycle; 8'h00 means idle
//   inj_out_o    : byte to switch pe_fifo_in, 8'h00 when not injecting
//   level_o      : current occupancy, 0..DEPTH
//   starve_o     : blocked-cycle counter has reached STARVE_MAX
//   drop_cnt_o   : saturating count of discarded self-addressed tokens
module pe_inject_queue #(
  parameter int RANK       = 0,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pe_inject_queue_if.slave       pe,
  input  logic [7:0]             ring_snoop_i,
  output logic [7:0]             inj_out_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   starve_o,
  output logic [7:0]             drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] blk_q, blk_d;
  logic          starve_q, starve_d;
  logic [7:0]    drop_q, drop_d;

  logic       ready;
  logic       push;
  logic       store;
  logic       drop;
  logic       inj;
  logic [5:0] head;

  // Ready comes only from the registered level: a full queue stays not-ready
  // even in a cycle where it pops.
  assign ready       = (level_q < LW'(DEPTH));
  assign pe.pe_ready = ready;

  assign push  = pe.pe_valid && ready;
  assign store = push && (pe.pe_data[5:4] != 2'(RANK));
  assign drop  = push && (pe.pe_data[5:4] == 2'(RANK));

  // Inject only into an idle ring slot; the switch favours PE input, so this
  // is what keeps ring tokens from being overwritten.
  assign inj  = (level_q != '0) && (ring_snoop_i == 8'h00);
  assign head = mem_q[rd_ptr_q];

  // Bit 7 set keeps a payload-0 token distinguishable from the idle byte.
  assign inj_out_o  = inj ? {2'b10, head} : 8'h00;
  assign level_o    = level_q;
  assign starve_o   = starve_q;
  assign drop_cnt_o = drop_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    blk_d    = blk_q;

    if (store) wr_ptr_d = wr_ptr_q + 1'b1;
    if (inj)   rd_ptr_d = rd_ptr_q + 1'b1;

    case ({store, inj})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;

    // Counts edges where something is waiting but the ring is occupied.
    if (inj || (level_q == '0)) begin
      blk_d = '0;
    end else if ((ring_snoop_i != 8'h00) && (blk_q != CW'(STARVE_MAX))) begin
      blk_d = blk_q + 1'b1;
    end

    starve_d = (blk_d == CW'(STARVE_MAX));
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= pe.pe_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      blk_q    <= '0;
      starve_q <= 1'b0;
      drop_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      blk_q    <= blk_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_pe_inject_queue.sv
// tb/tb_pe_inject_queue.sv - directed vector bench for pe_inject_queue
module tb_pe_inject_queue;

  logic       clk;
  logic       rst_n;
  logic [7:0] ring;
  logic [7:0] inj;
  logic [2:0] level;
  logic       starve;
  logic [7:0] drop;

  pe_inject_queue_if pe_if ();

  pe_inject_queue #(.RANK(0), .DEPTH(4), .STARVE_MAX(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pe           (pe_if),
    .ring_snoop_i (ring),
    .inj_out_o    (inj),
    .level_o      (level),
    .starve_o     (starve),
    .drop_cnt_o   (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [5:0] d;
    logic [7:0] rs;
    logic [7:0] e_inj;
    int         e_lvl;
    logic       e_rdy;
    logic       e_stv;
    logic [7:0] e_drp;
  } vec_t;

  vec_t       tbl [14];
  int         n_cmp;
  int         n_fail;
  logic [5:0] mq [$];
  logic [7:0] exp_out [4];
  int         sent;
  int         got;
  int         ml;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    ring   = 8'h00;
    pe_if.pe_valid = 1'b0;
    pe_if.pe_data  = 6'h00;

    //        v     d      ring   inj    lvl rdy   stv   drop
    tbl[0]  = '{1'b0, 6'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h00}; // reset state
    tbl[1]  = '{1'b1, 6'h15, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h00}; // push, no fall-through
    tbl[2]  = '{1'b0, 6'h00, 8'h00, 8'h95, 1, 1'b1, 1'b0, 8'h00}; // injected once
    tbl[3]  = '{1'b0, 6'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 6'h20, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h00}; // payload 0, dest 2
    tbl[5]  = '{1'b0, 6'h00, 8'h23, 8'h00, 1, 1'b1, 1'b0, 8'h00}; // ring busy holds it
    tbl[6]  = '{1'b0, 6'h00, 8'h00, 8'hA0, 1, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 6'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 6'h03, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h00}; // self-addressed
    tbl[9]  = '{1'b0, 6'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h01}; // dropped, counted
    tbl[10] = '{1'b1, 6'h31, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h01};
    tbl[11] = '{1'b1, 6'h12, 8'h00, 8'hB1, 1, 1'b1, 1'b0, 8'h01}; // push+pop at level 1
    tbl[12] = '{1'b0, 6'h00, 8'h00, 8'h92, 1, 1'b1, 1'b0, 8'h01}; // new token is head
    tbl[13] = '{1'b0, 6'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h01};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      pe_if.pe_valid = tbl[i].v;
      pe_if.pe_data  = tbl[i].d;
      ring           = tbl[i].rs;
      #1;
      chk($sformatf("vec%0d_inj", i), inj, tbl[i].e_inj);
      chk($sformatf("vec%0d_level", i), level, tbl[i].e_lvl);
      chk($sformatf("vec%0d_ready", i), pe_if.pe_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_starve", i), starve, tbl[i].e_stv);
      chk($sformatf("vec%0d_drop", i), drop, tbl[i].e_drp);
      tick();
    end
    pe_if.pe_valid = 1'b0;

    // Ring busy: fill, block, starve, then drain in order.
    exp_out[0] = 8'h91; exp_out[1] = 8'hA2; exp_out[2] = 8'hB3; exp_out[3] = 8'h94;
    ring = 8'h23;
    pe_if.pe_valid = 1'b1;
    pe_if.pe_data = 6'h11; tick();
    pe_if.pe_data = 6'h22; tick();
    pe_if.pe_data = 6'h33; tick();
    pe_if.pe_data = 6'h14; tick();
    pe_if.pe_data = 6'h15;
    #1;
    chk("full_level", level, 4);
    chk("full_ready", pe_if.pe_ready, 0);
    chk("full_inj", inj, 8'h00);
    chk("full_starve_early", starve, 0);
    tick();
    pe_if.pe_valid = 1'b0;
    #1;
    chk("full_no_accept", level, 4);
    repeat (10) tick();
    chk("starve_at_14", starve, 0);
    tick();
    chk("starve_at_15", starve, 1);
    repeat (5) tick();
    chk("starve_held", starve, 1);
    chk("blocked_inj", inj, 8'h00);
    for (int i = 0; i < 4; i++) begin
      ring = 8'h00;
      #1;
      chk($sformatf("drain%0d_inj", i), inj, exp_out[i]);
      chk($sformatf("drain%0d_level", i), level, 4 - i);
      if (i == 0) chk("drain_starve_pre", starve, 1);
      tick();
    end
    #1;
    chk("drain_level", level, 0);
    chk("drain_starve", starve, 0);
    chk("drain_inj", inj, 8'h00);

    // Drop counter saturation: 300 self-addressed pushes on top of 1.
    pe_if.pe_valid = 1'b1;
    pe_if.pe_data  = 6'h03;
    repeat (253) tick();
    chk("drop_fe", drop, 8'hFE);
    repeat (47) tick();
    chk("drop_sat", drop, 8'hFF);
    chk("drop_level", level, 0);
    pe_if.pe_valid = 1'b0;

    // Continuous push with alternating ring, checked against a queue model.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 120 && got < 20; cyc++) begin
      ring = cyc[0] ? 8'h00 : 8'h5A;
      pe_if.pe_valid = (sent < 20);
      pe_if.pe_data  = {2'(1 + sent % 3), 4'(sent)};
      #1;
      ml = mq.size();
      chk("stream_level", level, ml);
      chk("stream_ready", pe_if.pe_ready, int'(ml < 4));
      if (ml != 0 && ring == 8'h00) begin
        chk("stream_inj", inj, {2'b10, mq[0]});
        void'(mq.pop_front());
        got++;
      end else begin
        chk("stream_idle", inj, 8'h00);
      end
      if (pe_if.pe_valid && ml < 4) begin
        mq.push_back(pe_if.pe_data);
        sent++;
      end
      tick();
    end
    pe_if.pe_valid = 1'b0;
    chk("stream_count", got, 20);

    // Asynchronous reset with tokens queued.
    ring = 8'h23;
    pe_if.pe_valid = 1'b1;
    pe_if.pe_data = 6'h11; tick();
    pe_if.pe_data = 6'h22; tick();
    pe_if.pe_data = 6'h33; tick();
    pe_if.pe_valid = 1'b0;
    #1;
    chk("pre_rst_level", level, 3);
    #2;
    rst_n = 1'b0;
    ring  = 8'h00;
    #1;
    chk("rst_level", level, 0);
    chk("rst_inj", inj, 8'h00);
    chk("rst_ready", pe_if.pe_ready, 1);
    chk("rst_drop", drop, 8'h00);
    chk("rst_starve", starve, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_inj", inj, 8'h00);
      chk("post_rst_level", level, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
